// File: rtl/calc1_pkg.sv
// Shared encodings and widths for the calc1 request/response protocol.
package calc1_pkg;
    localparam int DATA_W = 32;

    typedef enum logic [3:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_SHL = 4'd5,
        CMD_SHR = 4'd6
    } cmd_e;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_OK   = 2'd1,
        RESP_ERR  = 2'd2
    } resp_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OP2,
        ST_EXEC,
        ST_RESP
    } state_e;
endpackage

// File: rtl/calc1_port_responder_if.sv
// calc1 request/response bundle; master is the requester, slave the responder.
interface calc1_port_responder_if;
    import calc1_pkg::*;

    logic [3:0]        req_cmd_in;
    logic [DATA_W-1:0] req_data_in;
    logic [1:0]        out_resp;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              proto_err;

    modport master (
        output req_cmd_in, req_data_in,
        input  out_resp, out_data, busy, proto_err
    );

    modport slave (
        input  req_cmd_in, req_data_in,
        output out_resp, out_data, busy, proto_err
    );
endinterface

// File: rtl/calc1_alu.sv
// Combinational add/sub/shift with overflow, underflow and invalid-command detection.
// Error responses always carry zero data.
module calc1_alu
    import calc1_pkg::*;
(
    input  logic [3:0]        i_cmd,
    input  logic [DATA_W-1:0] i_op1,
    input  logic [DATA_W-1:0] i_op2,
    output resp_e             o_resp,
    output logic [DATA_W-1:0] o_data
);
    logic [DATA_W:0] w_sum;

    assign w_sum = {1'b0, i_op1} + {1'b0, i_op2};

    always_comb begin
        o_resp = RESP_ERR;
        o_data = '0;
        case (i_cmd)
            CMD_ADD: begin
                if (!w_sum[DATA_W]) begin
                    o_resp = RESP_OK;
                    o_data = w_sum[DATA_W-1:0];
                end
            end
            CMD_SUB: begin
                if (i_op2 <= i_op1) begin
                    o_resp = RESP_OK;
                    o_data = i_op1 - i_op2;
                end
            end
            // Only the low five bits of op2 form the shift amount.
            CMD_SHL: begin
                o_resp = RESP_OK;
                o_data = i_op1 << i_op2[4:0];
            end
            CMD_SHR: begin
                o_resp = RESP_OK;
                o_data = i_op1 >> i_op2[4:0];
            end
            default: begin
                o_resp = RESP_ERR;
                o_data = '0;
            end
        endcase
    end
endmodule

// File: rtl/calc1_port_responder.sv
// Per-port calc1 engine: cmd+op1, then op2, EXEC_CYCLES of execution, one-cycle response.
// No backpressure: commands arriving outside IDLE are dropped and flag proto_err.
module calc1_port_responder
    import calc1_pkg::*;
#(
    parameter int EXEC_CYCLES = 1,
    parameter int DATA_W      = 32
) (
    input  logic                   c_clk,
    input  logic                   reset,
    calc1_port_responder_if.slave  bus
);
    state_e              r_state;
    state_e              w_next;
    logic [3:0]          r_cmd;
    logic [DATA_W-1:0]   r_op1;
    logic [DATA_W-1:0]   r_op2;
    logic [3:0]          r_cnt;
    logic [1:0]          r_resp;
    logic [DATA_W-1:0]   r_data;
    logic                r_perr;
    logic                w_last;
    resp_e               w_alu_resp;
    logic [DATA_W-1:0]   w_alu_data;

    assign w_last = (r_cnt == 4'(EXEC_CYCLES - 1));

    calc1_alu u_alu (
        .i_cmd  (r_cmd),
        .i_op1  (r_op1),
        .i_op2  (r_op2),
        .o_resp (w_alu_resp),
        .o_data (w_alu_data)
    );

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.req_cmd_in != CMD_NOP) w_next = ST_OP2;
            ST_OP2:  w_next = ST_EXEC;
            ST_EXEC: if (w_last) w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (r_state != ST_IDLE);
        bus.out_resp  = r_resp;
        bus.out_data  = r_data;
        bus.proto_err = r_perr;
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            r_cmd  <= '0;
            r_op1  <= '0;
            r_op2  <= '0;
            r_cnt  <= '0;
            r_resp <= '0;
            r_data <= '0;
            r_perr <= 1'b0;
        end else begin
            if (r_state != ST_IDLE && bus.req_cmd_in != CMD_NOP) r_perr <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_cmd_in != CMD_NOP) begin
                        r_cmd <= bus.req_cmd_in;
                        r_op1 <= bus.req_data_in;
                    end
                end
                ST_OP2: begin
                    r_op2 <= bus.req_data_in;
                    r_cnt <= '0;
                end
                ST_EXEC: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (w_last) begin
                        r_resp <= w_alu_resp;
                        r_data <= w_alu_data;
                    end
                end
                ST_RESP: begin
                    r_resp <= '0;
                    r_data <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_calc1_port_responder.sv
// Scoreboard bench for calc1_port_responder: directed vectors, queue of expected responses.
module tb_calc1_port_responder;
    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
        logic [31:0] cyc;
    } exp_t;

    logic        c_clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cyc   = '0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb_q[$];

    calc1_port_responder_if u_if ();
    calc1_port_responder_if u_if4 ();

    calc1_port_responder #(.EXEC_CYCLES(1)) u_dut (
        .c_clk (c_clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    calc1_port_responder #(.EXEC_CYCLES(4)) u_dut4 (
        .c_clk (c_clk),
        .reset (reset),
        .bus   (u_if4.slave)
    );

    always #5 c_clk = ~c_clk;
    always @(posedge c_clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Monitor: every nonzero response must match the head of the scoreboard.
    always @(negedge c_clk) begin
        if (!reset) begin
            if (u_if.out_resp != 2'd0) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp got %h data %h", u_if.out_resp, u_if.out_data);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (u_if.out_resp !== e.resp || u_if.out_data !== e.data || cyc !== e.cyc) begin
                        errors++;
                        $display("FAIL resp got %h/%h@%0d want %h/%h@%0d",
                                 u_if.out_resp, u_if.out_data, cyc, e.resp, e.data, e.cyc);
                    end
                end
            end else if (u_if.out_data != 32'd0) begin
                checks++;
                errors++;
                $display("FAIL idle_data got %h want 0", u_if.out_data);
            end
        end
    end

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge c_clk);
            if (!u_if.busy) done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout got busy want idle");
        end
    endtask

    task automatic send(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2,
                        input logic [1:0] er, input logic [31:0] ed);
        exp_t e;
        @(negedge c_clk);
        u_if.req_cmd_in  = cmd;
        u_if.req_data_in = op1;
        e.resp = er;
        e.data = ed;
        e.cyc  = cyc + 32'd3;
        sb_q.push_back(e);
        @(negedge c_clk);
        u_if.req_cmd_in  = 4'd0;
        u_if.req_data_in = op2;
        @(negedge c_clk);
        u_if.req_data_in = 32'd0;
        wait_idle();
    endtask

    initial begin
        exp_t        e;
        logic [31:0] k;
        int          busy_cnt;
        logic [31:0] resp_cyc;
        logic [1:0]  resp4;
        logic [31:0] data4;

        u_if.req_cmd_in   = 4'd0;
        u_if.req_data_in  = 32'd0;
        u_if4.req_cmd_in  = 4'd0;
        u_if4.req_data_in = 32'd0;
        repeat (3) @(negedge c_clk);
        chk("rst_resp", {30'd0, u_if.out_resp}, 32'd0);
        chk("rst_data", u_if.out_data, 32'd0);
        chk("rst_busy", {31'd0, u_if.busy}, 32'd0);
        chk("rst_perr", {31'd0, u_if.proto_err}, 32'd0);
        reset = 1'b0;
        @(negedge c_clk);

        send(4'd1, 32'h0000_0001, 32'h01FF_FFFF, 2'd1, 32'h0200_0000);
        send(4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0);
        send(4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 2'd1, 32'h3FFF_FFFE);
        send(4'd2, 32'h1,         32'hF,         2'd2, 32'h0);
        send(4'd2, 32'hF,         32'h1,         2'd1, 32'hE);
        send(4'd2, 32'h5,         32'h5,         2'd1, 32'h0);
        send(4'd5, 32'h1,         32'h0000_0021, 2'd1, 32'h2);
        send(4'd6, 32'h8000_0000, 32'h1F,        2'd1, 32'h1);
        send(4'd6, 32'h1234_5678, 32'hFFFF_FFE0, 2'd1, 32'h1234_5678);
        send(4'd3, 32'h1,         32'h1,         2'd2, 32'h0);
        send(4'd4, 32'h1,         32'h1,         2'd2, 32'h0);
        send(4'hF, 32'h1,         32'h1,         2'd2, 32'h0);
        chk("perr_clean", {31'd0, u_if.proto_err}, 32'd0);

        // Second command during OP2 must be dropped; in-flight response unaffected.
        @(negedge c_clk);
        u_if.req_cmd_in  = 4'd1;
        u_if.req_data_in = 32'd1;
        e.resp = 2'd1;
        e.data = 32'd3;
        e.cyc  = cyc + 32'd3;
        sb_q.push_back(e);
        @(negedge c_clk);
        u_if.req_cmd_in  = 4'd1;
        u_if.req_data_in = 32'd2;
        @(negedge c_clk);
        u_if.req_cmd_in  = 4'd0;
        u_if.req_data_in = 32'd0;
        wait_idle();
        repeat (3) @(negedge c_clk);
        chk("perr_set", {31'd0, u_if.proto_err}, 32'd1);
        send(4'd1, 32'd10, 32'd20, 2'd1, 32'd30);
        chk("perr_sticky", {31'd0, u_if.proto_err}, 32'd1);

        // Reset while in EXEC: outputs clear at once and no response follows.
        @(negedge c_clk);
        u_if.req_cmd_in  = 4'd1;
        u_if.req_data_in = 32'd5;
        @(negedge c_clk);
        u_if.req_cmd_in  = 4'd0;
        u_if.req_data_in = 32'd6;
        @(negedge c_clk);
        u_if.req_data_in = 32'd0;
        chk("exec_busy", {31'd0, u_if.busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_busy", {31'd0, u_if.busy}, 32'd0);
        chk("arst_perr", {31'd0, u_if.proto_err}, 32'd0);
        chk("arst_resp", {30'd0, u_if.out_resp}, 32'd0);
        chk("arst_data", u_if.out_data, 32'd0);
        repeat (2) @(negedge c_clk);
        reset = 1'b0;
        repeat (4) @(negedge c_clk);
        send(4'd2, 32'd100, 32'd1, 2'd1, 32'd99);

        // EXEC_CYCLES=4 instance: latency and busy window.
        @(negedge c_clk);
        k = cyc;
        u_if4.req_cmd_in  = 4'd1;
        u_if4.req_data_in = 32'h0000_0001;
        busy_cnt = 0;
        resp_cyc = 32'hFFFF_FFFF;
        resp4    = 2'd0;
        data4    = 32'd0;
        for (int i = 0; i < 12; i++) begin
            @(negedge c_clk);
            if (i == 0) begin
                u_if4.req_cmd_in  = 4'd0;
                u_if4.req_data_in = 32'h01FF_FFFF;
            end else if (i == 1) begin
                u_if4.req_data_in = 32'd0;
            end
            if (u_if4.busy) busy_cnt++;
            if (u_if4.out_resp != 2'd0) begin
                if (resp_cyc != 32'hFFFF_FFFF) begin
                    checks++;
                    errors++;
                    $display("FAIL e4_extra_resp got %h want 0", u_if4.out_resp);
                end
                resp_cyc = cyc;
                resp4    = u_if4.out_resp;
                data4    = u_if4.out_data;
            end
        end
        chk("e4_latency", resp_cyc, k + 32'd6);
        chk("e4_resp", {30'd0, resp4}, 32'd1);
        chk("e4_data", data4, 32'h0200_0000);
        chk("e4_busy", busy_cnt, 32'd6);

        repeat (4) @(negedge c_clk);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
